// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
package mult_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = 6;

  localparam logic [CNT_W-1:0] ITER_SIGNED        = 6'd32;
  localparam logic [CNT_W-1:0] ITER_UNSIGNED      = 6'd33;
  localparam logic [CNT_W-1:0] ITER_SIGNED_LAST   = ITER_SIGNED - 6'd1;
  localparam logic [CNT_W-1:0] ITER_UNSIGNED_LAST = ITER_UNSIGNED - 6'd1;
  localparam logic [CNT_W-1:0] CNT_ONE            = 6'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // {q0, q-1}: 01 -> add M, 10 -> subtract M, 00/11 -> nothing.
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    booth_op_t op;
    case (pair)
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: add/sub on the upper accumulator,
// then arithmetic right shift of the whole product register.
module booth_step
  import mult_pkg::*;
#(
  parameter int PW = 66,
  parameter int UW = 33
) (
  input  logic [PW-1:0] i_p,
  input  logic [UW-1:0] i_m,
  output logic [PW-1:0] o_p
);

  localparam int LW = PW - UW;

  logic [UW-1:0] w_upper;
  logic [UW-1:0] w_sum;
  booth_op_t     w_op;

  assign w_upper = i_p[PW-1 -: UW];
  assign w_op    = booth_decode(i_p[1:0]);

  always_comb begin
    w_sum = w_upper;
    case (w_op)
      OP_ADD:  w_sum = w_upper + i_m;
      OP_SUB:  w_sum = w_upper - i_m;
      default: w_sum = w_upper;
    endcase
  end

  // Low bit of the old register drops out; the sign of the new accumulator fills in.
  assign o_p = {w_sum[UW-1], w_sum, i_p[LW-1:1]};

endmodule

// File: rtl/mult_booth.sv
// Multicycle signed WIDTHxWIDTH radix-2 Booth multiplier, one step per clock.
// Optional MULT_UNSIGNED_EN adds a sign input selecting signed (MULT) or unsigned (MULTU).
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// RUN   | one Booth step per clock until the iteration count is reached
// DONE  | product copied to himult/lomult, done pulses next cycle
module mult_booth
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
`ifdef MULT_UNSIGNED_EN
  input  logic             sign,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] himult,
  output logic [WIDTH-1:0] lomult,
  output logic             busy,
  output logic             done
);

  // 33-bit accumulator keeps -2^31 * -2^31 from overflowing.
  localparam int UW = WIDTH + 1;
`ifdef MULT_UNSIGNED_EN
  localparam int PW = 2 * WIDTH + 3;
`else
  localparam int PW = 2 * WIDTH + 2;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [UW-1:0]    r_m;
  logic [PW-1:0]    r_p;
  logic [PW-1:0]    w_p_step;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last_cnt;
  logic             w_last;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

`ifdef MULT_UNSIGNED_EN
  logic r_sign;
  assign w_last_cnt = r_sign ? ITER_SIGNED_LAST : ITER_UNSIGNED_LAST;
`else
  assign w_last_cnt = ITER_SIGNED_LAST;
`endif

  assign w_last = (r_cnt == w_last_cnt);

  booth_step #(
    .PW(PW),
    .UW(UW)
  ) u_step (
    .i_p(r_p),
    .i_m(r_m),
    .o_p(w_p_step)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_m    <= '0;
      r_p    <= '0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
`ifdef MULT_UNSIGNED_EN
      r_sign <= 1'b0;
`endif
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt <= '0;
`ifdef MULT_UNSIGNED_EN
            r_sign <= sign;
            if (sign) begin
              r_m <= {A[WIDTH-1], A};
              r_p <= {{UW{1'b0}}, B[WIDTH-1], B, 1'b0};
            end else begin
              r_m <= {1'b0, A};
              r_p <= {{UW{1'b0}}, 1'b0, B, 1'b0};
            end
`else
            r_m <= {A[WIDTH-1], A};
            r_p <= {{UW{1'b0}}, B, 1'b0};
`endif
          end
        end
        RUN: begin
          r_p   <= w_p_step;
          r_cnt <= r_cnt + CNT_ONE;
        end
        DONE: begin
`ifdef MULT_UNSIGNED_EN
          // Signed runs one step fewer, so the product sits one bit higher.
          if (r_sign) begin
            r_hi <= r_p[2*WIDTH+1:WIDTH+2];
            r_lo <= r_p[WIDTH+1:2];
          end else begin
            r_hi <= r_p[2*WIDTH:WIDTH+1];
            r_lo <= r_p[WIDTH:1];
          end
`else
          r_hi <= r_p[2*WIDTH:WIDTH+1];
          r_lo <= r_p[WIDTH:1];
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = r_done;
  assign himult = r_hi;
  assign lomult = r_lo;

endmodule

// File: tb/tb_mult_booth.sv
// Scoreboard bench for mult_booth: stimulus pushes expected products and done cycles,
// a negedge monitor pops and compares whenever done is seen.
module tb_mult_booth;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] himult;
  logic [31:0] lomult;
  logic        busy;
  logic        done;
`ifdef MULT_UNSIGNED_EN
  logic        sign = 1'b1;
`endif

  mult_booth #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
`ifdef MULT_UNSIGNED_EN
    .sign  (sign),
`endif
    .A     (A),
    .B     (B),
    .himult(himult),
    .lomult(lomult),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: done with nothing pending (cycle %0d)", cycle);
      end else begin
        e = sb.pop_front();
        check("product", {himult, lomult}, {e.hi, e.lo});
        check("done_cycle", 64'(cycle), 64'(e.at));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Called at a negedge; start is sampled on the following posedge k.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input int steps, input bit push);
    exp_t e;
    A = a;
    B = b;
    start = 1'b1;
    if (push) begin
      e.hi = exp_hi;
      e.lo = exp_lo;
      e.at = cycle + 1 + steps + 1;
      sb.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: %0d results still pending after %0d cycles", sb.size(), n);
      sb.delete();
    end
    @(negedge clock);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_hi", 64'(himult), 64'd0);
    check("rst_lo", 64'(lomult), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    issue(32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 32, 1);
    wait_idle();
    issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 1);
    wait_idle();
    issue(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 32, 1);
    wait_idle();
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 32, 1);
    wait_idle();

    // Start re-pulsed mid-run must be ignored.
    issue(32'd7, 32'd9, 32'h0, 32'd63, 32, 1);
    repeat (5) @(negedge clock);
    A = 32'd2;
    B = 32'd2;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clock);
    check("hold_after_done", {himult, lomult}, 64'd63);

    // Reset mid-run aborts: outputs clear, no done.
    issue(32'd7, 32'd9, 32'h0, 32'h0, 32, 0);
    repeat (8) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_out", {himult, lomult}, 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    issue(32'hFFFF_FFFA, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 32, 1);
    wait_idle();

    // start held high: back-to-back operations every 34 cycles.
    A = 32'hFFFF_FFFD;
    B = 32'd100;
    start = 1'b1;
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FED4, at: cycle + 1 + 33});
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FED4, at: cycle + 1 + 67});
    repeat (35) @(negedge clock);
    start = 1'b0;
    wait_idle();

`ifdef MULT_UNSIGNED_EN
    sign = 1'b0;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1);
    wait_idle();
    issue(32'h8000_0000, 32'd2, 32'h0000_0001, 32'h0000_0000, 33, 1);
    wait_idle();
    sign = 1'b1;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32, 1);
    wait_idle();
    issue(32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0000_0000, 32, 1);
    wait_idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
